percept_control_p: RTL and testbench
====================================

PERCEPT_CONTROL_P -- requirements
Module: percept_control_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, node address width in bits.
REQ-002 SHALL have parameter OP_W, default 3, opcode field width in bits.
REQ-003 SHALL have parameter DATA_W, default 62, data field width in bits.
REQ-004 SHALL have parameter BCAST_EN, default 1, accept the all-ones broadcast address when 1.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port address  input  ADDR_W  this node's address, static during operation.
REQ-008 SHALL have port rx  input  1  serial frame line, idle high, one bit per clk, synchronous to clk.
REQ-009 SHALL have port opcode  output  OP_W  opcode of the last accepted frame.
REQ-010 SHALL have port data  output  DATA_W  data of the last accepted frame.
REQ-011 SHALL have port valid  output  1  one-cycle strobe, new frame accepted.
REQ-012 SHALL have port err  output  1  one-cycle strobe, framing error (bad stop bit).
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL frame as: start bit 0, ADDR_W address bits, OP_W opcode bits, DATA_W data bits, stop bit 1; all fields MSB first; total ADDR_W+OP_W+DATA_W+2 bits.
REQ-015 SHALL implement states IDLE, ADDR, OP, DATA, STOP, WAIT_HI.
REQ-016 SHALL in IDLE move to ADDR on the edge sampling rx=0; stay in IDLE while rx=1.
REQ-017 SHALL in ADDR, OP, DATA shift one rx bit per edge into the field shift register, using a down-counter loaded with field width minus 1, advancing state on the edge sampling count 0.
REQ-018 SHALL size the bit counter as clog2 of max(ADDR_W, OP_W, DATA_W); no counter wrap beyond the field width.
REQ-019 SHALL set internal match at the end of ADDR when the received address equals address, or equals all ones with BCAST_EN=1.
REQ-020 SHALL continue through OP and DATA on a mismatch so framing is preserved, without touching outputs.
REQ-021 SHALL in STOP, if rx=1 and match: load opcode and data, pulse valid for exactly the next cycle, go to IDLE.
REQ-022 SHALL in STOP, if rx=1 and no match: go to IDLE silently, no strobe, outputs held.
REQ-023 SHALL in STOP, if rx=0: pulse err for the next cycle regardless of match, outputs held, go to WAIT_HI.
REQ-024 SHALL in WAIT_HI return to IDLE only on the edge sampling rx=1, so a stuck-low line is never taken as a start bit.
REQ-025 SHALL accept a start bit on the cycle immediately following a valid stop bit (back-to-back frames, no idle gap required).
REQ-026 SHALL hold opcode and data constant between accepted frames; valid and err are never high together.
REQ-027 SHALL have valid latency of one cycle after the edge that samples the stop bit, i.e. valid high in cycle ADDR_W+OP_W+DATA_W+2 counted from the start-bit edge.

Reset
REQ-028 SHALL on rst=1, asynchronously and at any point including mid-frame: state IDLE, counter 0, shift registers 0, opcode 0, data 0, valid 0, err 0, busy 0.
REQ-029 SHALL after rst deasserts resume in IDLE on the next edge, ignoring any partial frame in progress.

Verification
REQ-030 SHALL cover: address=8'hAA, frame addr AA, op 4, data 100 -> valid one cycle, 75 cycles after start edge, opcode=4, data=100, err=0.
REQ-031 SHALL cover: frame addr 55, op 2, data 7 -> no valid, no err, opcode=4/data=100 held, busy low after 75 cycles.
REQ-032 SHALL cover: frame addr FF, op 1, data 3 with BCAST_EN=1 -> valid, opcode=1, data=3; same with BCAST_EN=0 -> ignored.
REQ-033 SHALL cover: frame addr AA with stop bit 0, rx held low 5 more cycles -> err one cycle, outputs held, busy high until rx=1, then IDLE.
REQ-034 SHALL cover: rst pulsed after 20 frame bits -> all outputs 0 immediately, busy 0; following full frame addr AA op 6 data 1 -> accepted.
REQ-035 SHALL cover: two matching frames back-to-back, second start bit directly after first stop bit -> two valid pulses 75 cycles apart, second values on outputs.

Source files
------------

// File: rtl/percept_control_p.sv
// ----------------------------------------------------------------------------
// percept_control_p
//
// Serial frame receiver for an addressed node on a shared, idle-high line.
// The line carries one bit per clk, synchronous to clk. A frame looks like
// this, with every field sent MSB first:
//
//   start(0) | address[ADDR_W] | opcode[OP_W] | data[DATA_W] | stop(1)
//
// A frame is accepted when its address equals this node's address. When
// BCAST_EN is set, the all-ones broadcast address is accepted as well. On
// acceptance the opcode and data fields are published and `valid` pulses for
// one cycle. A frame for another node is still clocked through to its stop
// bit so that framing stays aligned, but it leaves the outputs untouched.
// A bad stop bit pulses `err`. The receiver then waits for the line to
// return high before it looks for the next start bit.
//
// Parameters
//   ADDR_W    node address width in bits
//   OP_W      opcode field width in bits
//   DATA_W    data field width in bits
//   BCAST_EN  nonzero: also accept the all-ones broadcast address
//
// Ports
//   clk      in   system clock; all state changes on the rising edge
//   rst      in   asynchronous active-high reset
//   address  in   this node's address, static during operation
//   rx       in   serial frame line, idle high
//   opcode   out  opcode of the last accepted frame
//   data     out  data of the last accepted frame
//   valid    out  one-cycle strobe: a new frame was accepted
//   err      out  one-cycle strobe: framing error (stop bit was 0)
//   busy     out  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module percept_control_p #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OP_W     = 3,
    parameter int unsigned DATA_W   = 62,
    parameter int unsigned BCAST_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              rx,
    output logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err,
    output logic              busy
);

    // The bit counter only needs to reach (widest field - 1). Widths of 1
    // would make $clog2 return 0, so the counter is kept at least 1 bit wide.
    localparam int unsigned MAX_W = (ADDR_W > OP_W)
                                  ? ((ADDR_W > DATA_W) ? ADDR_W : DATA_W)
                                  : ((OP_W   > DATA_W) ? OP_W   : DATA_W);
    localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_OP      = 3'd2,
        S_DATA    = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_sr_q;
    logic [OP_W-1:0]     op_sr_q;
    logic [DATA_W-1:0]   data_sr_q;
    logic                match_q;
    logic [OP_W-1:0]     opcode_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                err_q;

    // Each shift register's value after the current rx bit is shifted in at
    // the LSB end (the fields arrive MSB first). The cast drops the bit that
    // falls off the top, and it still works when a field is only 1 bit wide.
    logic [ADDR_W-1:0]   addr_sr_d;
    logic [OP_W-1:0]     op_sr_d;
    logic [DATA_W-1:0]   data_sr_d;
    logic                addr_match_d;

    assign addr_sr_d = ADDR_W'({addr_sr_q, rx});
    assign op_sr_d   = OP_W'({op_sr_q, rx});
    assign data_sr_d = DATA_W'({data_sr_q, rx});

    // The match is evaluated on the complete address, which includes the
    // last address bit being sampled on this edge.
    assign addr_match_d = (addr_sr_d == address)
                       || ((BCAST_EN != 0) && (addr_sr_d == '1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register is cleared here, the shift registers
            // included. A reset in the middle of a frame must leave no
            // trace of the partial frame, and a reset value is defined for
            // all state.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_sr_q <= '0;
            op_sr_q   <= '0;
            data_sr_q <= '0;
            match_q   <= 1'b0;
            opcode_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: only non-blocking assignments are used in this block, so
            // every branch reads the state from before this edge. The strobes
            // default low here, and the branches below override them.
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rx) begin
                        state_q <= S_ADDR;
                        cnt_q   <= ADDR_LAST;
                    end
                end

                S_ADDR: begin
                    addr_sr_q <= addr_sr_d;
                    if (cnt_q == '0) begin
                        match_q <= addr_match_d;
                        cnt_q   <= OP_LAST;
                        state_q <= S_OP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_OP: begin
                    op_sr_q <= op_sr_d;
                    if (cnt_q == '0) begin
                        cnt_q   <= DATA_LAST;
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_DATA: begin
                    data_sr_q <= data_sr_d;
                    if (cnt_q == '0) begin
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (rx) begin
                        // A good stop bit returns straight to IDLE. The next
                        // edge can therefore take a back-to-back start bit.
                        if (match_q) begin
                            opcode_q <= op_sr_q;
                            data_q   <= data_sr_q;
                            valid_q  <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_WAIT_HI;
                    end
                end

                S_WAIT_HI: begin
                    // A line stuck low must not look like a fresh start bit.
                    // Wait until the line goes high again.
                    if (rx) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign opcode = opcode_q;
    assign data   = data_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_percept_control_p.sv
// ----------------------------------------------------------------------------
// tb_percept_control_p
//
// Two receivers listen on the same line: dut0 has BCAST_EN=1 and dut1 has
// BCAST_EN=0. The stimulus drives directed frames. For each frame, the
// stimulus pushes the expected strobe (valid or err), the held outputs, and
// the cycle in which the strobe should appear into one queue per receiver.
// Independent monitors pop and compare whenever a receiver strobes.
// ----------------------------------------------------------------------------
module tb_percept_control_p;

    localparam int ADDR_W = 8;
    localparam int OP_W   = 3;
    localparam int DATA_W = 62;
    localparam int FLEN   = ADDR_W + OP_W + DATA_W + 2;   // 75 bits

    typedef struct {
        logic              is_err;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address;
    logic              rx;

    logic [OP_W-1:0]   opcode0, opcode1;
    logic [DATA_W-1:0] data0, data1;
    logic              valid0, valid1, err0, err1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Outputs each receiver should currently be holding.
    logic [OP_W-1:0]   held_op0, held_op1;
    logic [DATA_W-1:0] held_data0, held_data1;

    percept_control_p #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DATA_W(DATA_W), .BCAST_EN(1)) dut0 (
        .clk(clk), .rst(rst), .address(address), .rx(rx),
        .opcode(opcode0), .data(data0), .valid(valid0), .err(err0), .busy(busy0)
    );

    percept_control_p #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DATA_W(DATA_W), .BCAST_EN(0)) dut1 (
        .clk(clk), .rst(rst), .address(address), .rx(rx),
        .opcode(opcode1), .data(data1), .valid(valid1), .err(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: compare every strobe with the head of its queue.
    always @(negedge clk) begin
        if (valid0 || err0) begin
            check("dut0 valid/err exclusive", 64'(valid0 && err0), 0);
            check("dut0 strobe expected", 64'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                exp_t e;
                e = q0.pop_front();
                check("dut0 strobe kind err", 64'(err0), 64'(e.is_err));
                check("dut0 strobe cycle", 64'(cyc), 64'(e.cyc));
                check("dut0 opcode", 64'(opcode0), 64'(e.op));
                check("dut0 data", 64'(data0), 64'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (valid1 || err1) begin
            check("dut1 valid/err exclusive", 64'(valid1 && err1), 0);
            check("dut1 strobe expected", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 strobe kind err", 64'(err1), 64'(e.is_err));
                check("dut1 strobe cycle", 64'(cyc), 64'(e.cyc));
                check("dut1 opcode", 64'(opcode1), 64'(e.op));
                check("dut1 data", 64'(data1), 64'(e.data));
            end
        end
    end

    // Drives one full frame, one bit per negedge. The expected response is
    // queued when the start bit is driven. Start-bit edge + 75 cycles is the
    // negedge on which valid/err is visible.
    task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [OP_W-1:0] o,
                              input logic [DATA_W-1:0] d, input logic stop);
        logic [FLEN-1:0] f;
        logic m0, m1;
        exp_t e0, e1;
        f  = {1'b0, a, o, d, stop};
        m0 = (a == address) || (a == 8'hFF);
        m1 = (a == address);
        for (int i = FLEN - 1; i >= 0; i--) begin
            @(negedge clk);
            rx = f[i];
            if (i == FLEN - 1) begin
                if (!stop) begin
                    e0 = '{1'b1, held_op0, held_data0, cyc + 75};
                    e1 = '{1'b1, held_op1, held_data1, cyc + 75};
                    q0.push_back(e0);
                    q1.push_back(e1);
                end else begin
                    if (m0) begin
                        held_op0 = o; held_data0 = d;
                        e0 = '{1'b0, o, d, cyc + 75};
                        q0.push_back(e0);
                    end
                    if (m1) begin
                        held_op1 = o; held_data1 = d;
                        e1 = '{1'b0, o, d, cyc + 75};
                        q1.push_back(e1);
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, " dut0 opcode held"}, 64'(opcode0), 64'(held_op0));
        check({tag, " dut0 data held"}, 64'(data0), 64'(held_data0));
        check({tag, " dut1 opcode held"}, 64'(opcode1), 64'(held_op1));
        check({tag, " dut1 data held"}, 64'(data1), 64'(held_data1));
    endtask

    initial begin
        logic [FLEN-1:0] pf;
        address    = 8'hAA;
        rx         = 1'b1;
        rst        = 1'b1;
        held_op0   = '0; held_data0 = '0;
        held_op1   = '0; held_data1 = '0;
        repeat (3) @(negedge clk);

        // Outputs while reset is held.
        check("reset opcode", 64'(opcode0), 0);
        check("reset data", 64'(data0), 0);
        check("reset valid/err", 64'({valid0, err0, valid1, err1}), 0);
        check("reset busy", 64'({busy0, busy1}), 0);
        rst = 1'b0;
        idle(3);
        check("idle busy", 64'({busy0, busy1}), 0);

        // Matching frame.
        send_frame(8'hAA, 3'd4, 62'd100, 1'b1);
        check("mid-stop busy", 64'({busy0, busy1}), 2'b11);
        idle(4);
        check("after frame1 opcode", 64'(opcode0), 4);
        check("after frame1 data", 64'(data0), 100);

        // Frame for another node: ignored, outputs held, back to idle.
        send_frame(8'h55, 3'd2, 62'd7, 1'b1);
        idle(2);
        check_held("non-match");
        check("non-match busy", 64'({busy0, busy1}), 0);

        // Broadcast: only the BCAST_EN=1 receiver accepts it.
        send_frame(8'hFF, 3'd1, 62'd3, 1'b1);
        idle(2);
        check("bcast dut0 opcode", 64'(opcode0), 1);
        check("bcast dut0 data", 64'(data0), 3);
        check("bcast dut1 opcode held", 64'(opcode1), 4);
        check("bcast dut1 data held", 64'(data1), 100);

        // Bad stop bit, then line held low: err, stay busy until line high.
        send_frame(8'hAA, 3'd5, 62'd9, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = 1'b0;
            check("wait_hi busy", 64'({busy0, busy1}), 2'b11);
        end
        check_held("framing error");
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("released busy", 64'({busy0, busy1}), 0);
        idle(2);

        // Reset after 20 frame bits: everything clears at once.
        pf = {1'b0, 8'hAA, 3'd3, 62'h15, 1'b1};
        for (int i = FLEN - 1; i >= FLEN - 20; i--) begin
            @(negedge clk);
            rx = pf[i];
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset opcode", 64'({opcode0, opcode1}), 0);
        check("async reset data", 64'(data0 | data1), 0);
        check("async reset busy", 64'({busy0, busy1}), 0);
        held_op0 = '0; held_data0 = '0;
        held_op1 = '0; held_data1 = '0;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        send_frame(8'hAA, 3'd6, 62'd1, 1'b1);
        idle(2);
        check("post-reset opcode", 64'(opcode1), 6);
        check("post-reset data", 64'(data1), 1);

        // Back-to-back frames; second carries all-ones data.
        send_frame(8'hAA, 3'd5, 62'h2, 1'b1);
        send_frame(8'hAA, 3'd7, {DATA_W{1'b1}}, 1'b1);
        idle(3);
        check_held("back-to-back");

        idle(5);
        check("dut0 queue drained", 64'(q0.size()), 0);
        check("dut1 queue drained", 64'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
